// File: rtl/mix_columns_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mix_columns_seq: sequenced AES MixColumns engine, one shared mixer     |
// | time-multiplexed over the four columns. Define INV_MIX_EN to build the |
// | InvMixColumns network.                                                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam logic [1:0] C_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] C_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MIX  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] f_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] f_mix_fwd(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] t [4];
    for (int k = 0; k < 4; k++) begin
      a[k] = c[31-8*k -: 8];
      t[k] = f_xtime(a[k]);
    end
    return {t[0] ^ t[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ t[1] ^ t[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ t[2] ^ t[3] ^ a[3],
            t[0] ^ a[0] ^ a[1] ^ a[2] ^ t[3]};
  endfunction

`ifdef INV_MIX_EN
  function automatic logic [31:0] f_mix_inv(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a  = c[31-8*k -: 8];
      x2 = f_xtime(a);
      x4 = f_xtime(x2);
      x8 = f_xtime(x4);
      m9[k] = x8 ^ a;
      mb[k] = x8 ^ x2 ^ a;
      md[k] = x8 ^ x4 ^ a;
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  state_t         r_state;
  logic [1:0]     r_col_cnt;
  logic [127:0]   r_work;
  logic [127:0]   r_state_out;
  logic           r_out_valid;
  logic           r_in_ready;
  logic           r_busy;
`ifdef INV_MIX_EN
  logic           r_mode;
`else
  logic           w_unused_inverse;
  assign w_unused_inverse = inverse;
`endif

  logic [31:0]    w_cols   [4];
  logic [31:0]    w_mixed  [COLS_PER_CYCLE];
  logic [127:0]   w_work_next;

  // Lane j of a pass handles column col_cnt+j.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    logic [1:0]  w_idx;
    logic [31:0] w_col_in;
    assign w_idx    = r_col_cnt + 2'(j);
    assign w_col_in = w_cols[w_idx];
`ifdef INV_MIX_EN
    assign w_mixed[j] = r_mode ? f_mix_inv(w_col_in) : f_mix_fwd(w_col_in);
`else
    assign w_mixed[j] = f_mix_fwd(w_col_in);
`endif
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    localparam logic [1:0] C_BASE = 2'(c - (c % COLS_PER_CYCLE));
    localparam int         C_LANE = c % COLS_PER_CYCLE;
    assign w_cols[c] = r_work[127-32*c -: 32];
    assign w_work_next[127-32*c -: 32] = (r_col_cnt == C_BASE) ? w_mixed[C_LANE] : w_cols[c];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_col_cnt   <= 2'd0;
      r_work      <= 128'd0;
      r_state_out <= 128'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef INV_MIX_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_work     <= state_in;
`ifdef INV_MIX_EN
            r_mode     <= inverse;
`endif
            r_col_cnt  <= 2'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MIX;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_MIX: begin
          r_work    <= w_work_next;
          r_col_cnt <= r_col_cnt + C_STEP;
          if (r_col_cnt == C_LAST) begin
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          // First OUT cycle publishes the result; it then holds until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_state_out <= r_work;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign state_out = r_state_out;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// Directed bench for mix_columns_seq: three instances (1, 2 and 4 columns per
// clock) share stimulus; results, latencies, backpressure and reset are checked.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         inverse;
  logic         out_ready;
  logic [127:0] state_in;
  logic [2:0]   ir, ov, bz;
  logic [127:0] so1, so2, so4;

  int errors = 0;
  int checks = 0;

  localparam int LAT [3] = '{5, 3, 2};

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(ir[0]),
    .inverse(inverse), .state_in(state_in), .out_valid(ov[0]),
    .out_ready(out_ready), .state_out(so1), .busy(bz[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(ir[1]),
    .inverse(inverse), .state_in(state_in), .out_valid(ov[1]),
    .out_ready(out_ready), .state_out(so2), .busy(bz[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(ir[2]),
    .inverse(inverse), .state_in(state_in), .out_valid(ov[2]),
    .out_ready(out_ready), .state_out(so4), .busy(bz[2]));

  function automatic logic [127:0] get_so(input int i);
    case (i)
      0:       return so1;
      1:       return so2;
      default: return so4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (ir != 3'b111 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_in_ready"}, 128'(ir), 128'd7);
  endtask

  task automatic run_vec(input int idx, input logic [127:0] din, input logic inv,
                         input logic [127:0] exp);
    int lat [3];
    wait_ready($sformatf("v%0d", idx));
    state_in = din;
    inverse  = inv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    state_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    inverse  = ~inv;
    chk($sformatf("v%0d_busy", idx), 128'(bz), 128'd7);
    lat = '{0, 0, 0};
    for (int c = 1; c <= 20; c++) begin
      step();
      for (int i = 0; i < 3; i++)
        if (ov[i] && lat[i] == 0) lat[i] = c;
      if (ov == 3'b111) break;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("v%0d_lat_u%0d", idx, i), 128'(lat[i]), 128'(LAT[i]));
      chk($sformatf("v%0d_out_u%0d", idx, i), get_so(i), exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d_drop", idx), {125'd0, ov, bz} , 128'd0);
    chk($sformatf("v%0d_ready_after", idx), 128'(ir), 128'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit stable;
    int n;

    vecs[0] = '{din: 128'hdb135345_f20a225c_01010101_c6c6c6c6, inv: 1'b0,
                exp: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
`ifdef INV_MIX_EN
    vecs[1] = '{din: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv: 1'b1,
                exp: 128'hdb135345_f20a225c_01010101_c6c6c6c6};
`else
    vecs[1] = '{din: 128'hdb135345_f20a225c_01010101_c6c6c6c6, inv: 1'b1,
                exp: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
`endif
    vecs[2] = '{din: 128'h2d26314c_d4d4d4d5_00000000_ffffffff, inv: 1'b0,
                exp: 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff};
    vecs[3] = '{din: 128'hdb135345_2d26314c_f20a225c_d4d4d4d5, inv: 1'b0,
                exp: 128'h8e4da1bc_4d7ebdf8_9fdc589d_d5d5d7d6};
    vecs[4] = '{din: 128'd0, inv: 1'b0, exp: 128'd0};
    vecs[5] = '{din: 128'hd4d4d4d5_2d26314c_ffffffff_db135345, inv: 1'b0,
                exp: 128'hd5d5d7d6_4d7ebdf8_ffffffff_8e4da1bc};

    n_rst     = 1'b0;
    in_valid  = 1'b0;
    inverse   = 1'b0;
    out_ready = 1'b0;
    state_in  = 128'd0;
    step();
    step();
    chk("rst_flags", {125'd0, ov, bz}, 128'd0);
    chk("rst_state_out", so1 | so2 | so4, 128'd0);
    n_rst = 1'b1;
    step();
    chk("rst_release_ready", 128'(ir), 128'd7);

    for (int v = 0; v < 6; v++)
      run_vec(v, vecs[v].din, vecs[v].inv, vecs[v].exp);

    // Backpressure with a new request held pending during OUT.
    wait_ready("bp");
    state_in = vecs[0].din;
    inverse  = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      step();
      n++;
    end
    chk("bp_valid_seen", 128'(ov[0]), 128'd1);
    state_in = vecs[2].din;
    in_valid = 1'b1;
    stable   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ov !== 3'b111 || ir !== 3'b000 || so1 !== vecs[0].exp) stable = 1'b0;
    end
    chk("bp_stable", 128'(stable), 128'd1);
    chk("bp_held_out", so1, vecs[0].exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_one_transfer", {125'd0, ov}, 128'd0);
    chk("bp_ready_next", 128'(ir), 128'd7);
    step();
    in_valid = 1'b0;
    chk("bp_pending_accepted", 128'(bz), 128'd7);
    n = 0;
    while (ov != 3'b111 && n < 20) begin
      step();
      n++;
    end
    chk("bp_pending_out1", so1, vecs[2].exp);
    chk("bp_pending_out4", so4, vecs[2].exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of MIX.
    wait_ready("rst2");
    state_in = vecs[3].din;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rst_mid_busy", 128'(bz[0]), 128'd1);
    n_rst = 1'b0;
    #1;
    chk("rst_mid_flags", {125'd0, ov, bz}, 128'd0);
    chk("rst_mid_state_out", so1 | so2 | so4, 128'd0);
    step();
    chk("rst_mid_held", {122'd0, ov, bz}, 128'd0);
    n_rst = 1'b1;
    step();
    chk("rst_mid_ready", 128'(ir), 128'd7);
    chk("rst_mid_no_output", {125'd0, ov}, 128'd0);

    run_vec(6, vecs[3].din, 1'b0, vecs[3].exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
